// File: rtl/crc_serial_gen_pkg.sv
// Shared types and polynomial constants for the serial USB CRC generator/checker.
package crc_serial_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        APPEND = 2'd2
    } crc_state_e;

    localparam logic [4:0]  CRC5_POLY      = 5'b00101;
    localparam logic [4:0]  CRC5_INIT      = 5'b11111;
    localparam logic [4:0]  CRC5_RESIDUAL  = 5'b01100;

    localparam logic [15:0] CRC16_POLY     = 16'h8005;
    localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

endpackage

// File: rtl/crc_serial_gen_if.sv
// Serial bit-path bundle between the packet serialiser (master) and the CRC block (slave).
interface crc_serial_gen_if #(
    parameter int WIDTH = 5
);
    logic             halt_tx;
    logic             cwe_z;
    logic             chck_enbl;
    logic             data_in;
    logic             data_out;
    logic             crc_done;
    logic             error;
    logic [WIDTH-1:0] crc_value;

    modport master (
        output halt_tx, cwe_z, chck_enbl, data_in,
        input  data_out, crc_done, error, crc_value
    );

    modport slave (
        input  halt_tx, cwe_z, chck_enbl, data_in,
        output data_out, crc_done, error, crc_value
    );
endinterface

// File: rtl/crc_serial_gen_lfsr.sv
// CRC shift register: load INIT, feedback update on one data bit, or plain shift-out.
module crc_serial_lfsr #(
    parameter int               WIDTH = 5,
    parameter logic [WIDTH-1:0] POLY  = 5'b00101,
    parameter logic [WIDTH-1:0] INIT  = 5'b11111
) (
    input  logic             clk_c,
    input  logic             reset,
    input  logic             en_i,
    input  logic             load_i,
    input  logic             shift_only_i,
    input  logic             data_i,
    output logic [WIDTH-1:0] crc_o
);

    logic [WIDTH-1:0] crc_q;
    logic [WIDTH-1:0] crc_d;
    logic             fb_s;

    // Next register value; load wins over update.
    always_comb begin
        fb_s  = data_i ^ crc_q[WIDTH-1];
        crc_d = crc_q;
        if (load_i) begin
            crc_d = INIT;
        end else if (en_i) begin
            if (shift_only_i) begin
                crc_d = {crc_q[WIDTH-2:0], 1'b0};
            end else begin
                crc_d = {crc_q[WIDTH-2:0], 1'b0} ^ (fb_s ? POLY : {WIDTH{1'b0}});
            end
        end else begin
            crc_d = crc_q;
        end
    end

    // CRC register with synchronous reset to INIT.
    always_ff @(posedge clk_c) begin
        if (reset) begin
            crc_q <= INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/crc_serial_gen.sv
// Serial CRC generator/checker: passes data through while accumulating, then appends
// the inverted remainder MSB first; a strobe compares the register against the residual.
module crc_serial_gen
    import crc_serial_pkg::*;
#(
    parameter int               WIDTH    = 5,
    parameter logic [WIDTH-1:0] POLY     = CRC5_POLY,
    parameter logic [WIDTH-1:0] INIT     = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] RESIDUAL = CRC5_RESIDUAL
) (
    input  logic             clk_c,
    input  logic             reset,
    crc_serial_gen_if.slave  bus
);

    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    crc_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             data_out_q, data_out_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic             lfsr_en_s, lfsr_load_s, lfsr_shift_s;
    logic [WIDTH-1:0] crc_s;

    crc_serial_lfsr #(
        .WIDTH (WIDTH),
        .POLY  (POLY),
        .INIT  (INIT)
    ) u_lfsr (
        .clk_c        (clk_c),
        .reset        (reset),
        .en_i         (lfsr_en_s),
        .load_i       (lfsr_load_s),
        .shift_only_i (lfsr_shift_s),
        .data_i       (bus.data_in),
        .crc_o        (crc_s)
    );

    // State and output registers.
    always_ff @(posedge clk_c) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= {CW{1'b0}};
            data_out_q <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_out_q <= data_out_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    // Next-state logic; a stall freezes the FSM.
    always_comb begin
        state_d = state_q;
        if (bus.halt_tx) begin
            state_d = state_q;
        end else begin
            case (state_q)
                IDLE:    state_d = bus.cwe_z ? IDLE : DATA;
                DATA:    state_d = bus.cwe_z ? APPEND : DATA;
                APPEND: begin
                    if (!bus.cwe_z) begin
                        state_d = DATA;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                    end else begin
                        state_d = APPEND;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath controls, serial output and check result.
    always_comb begin
        cnt_d        = cnt_q;
        data_out_d   = data_out_q;
        done_d       = 1'b0;
        error_d      = error_q;
        lfsr_en_s    = 1'b0;
        lfsr_load_s  = 1'b0;
        lfsr_shift_s = 1'b0;
        if (bus.halt_tx) begin
            cnt_d      = cnt_q;
            data_out_d = data_out_q;
        end else begin
            // Check sees the register before this edge's update.
            error_d = bus.chck_enbl ? (crc_s != RESIDUAL) : error_q;
            case (state_q)
                IDLE, DATA: begin
                    cnt_d = {CW{1'b0}};
                    if (bus.cwe_z) begin
                        data_out_d = 1'b0;
                    end else begin
                        data_out_d = bus.data_in;
                        lfsr_en_s  = 1'b1;
                    end
                end
                APPEND: begin
                    if (!bus.cwe_z) begin
                        data_out_d  = 1'b0;
                        cnt_d       = {CW{1'b0}};
                        lfsr_load_s = 1'b1;
                    end else if (cnt_q == CNT_LAST) begin
                        data_out_d  = ~crc_s[WIDTH-1];
                        cnt_d       = {CW{1'b0}};
                        done_d      = 1'b1;
                        lfsr_load_s = 1'b1;
                    end else begin
                        data_out_d   = ~crc_s[WIDTH-1];
                        cnt_d        = cnt_q + CW'(1);
                        lfsr_en_s    = 1'b1;
                        lfsr_shift_s = 1'b1;
                    end
                end
                default: begin
                    data_out_d  = 1'b0;
                    cnt_d       = {CW{1'b0}};
                    lfsr_load_s = 1'b1;
                end
            endcase
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.crc_done  = done_q;
    assign bus.error     = error_q;
    assign bus.crc_value = crc_s;

endmodule

// File: tb/tb_crc_serial_gen.sv
// Scoreboard bench for CRC5 and CRC16 instances driven with hand-computed directed vectors.
module tb_crc_serial_gen;
    import crc_serial_pkg::*;

    localparam int X = -1;

    logic clk_c = 1'b0;
    logic reset = 1'b1;
    always #5 clk_c = ~clk_c;

    crc_serial_gen_if #(.WIDTH(5))  if5 ();
    crc_serial_gen_if #(.WIDTH(16)) if16 ();

    crc_serial_gen #(.WIDTH(5), .POLY(CRC5_POLY), .INIT(CRC5_INIT), .RESIDUAL(CRC5_RESIDUAL))
        dut5 (.clk_c(clk_c), .reset(reset), .bus(if5.slave));
    crc_serial_gen #(.WIDTH(16), .POLY(CRC16_POLY), .INIT(CRC16_INIT), .RESIDUAL(CRC16_RESIDUAL))
        dut16 (.clk_c(clk_c), .reset(reset), .bus(if16.slave));

    typedef struct {
        bit          sel;
        int          cyc;
        bit          c_do;
        logic        do_v;
        bit          c_dn;
        logic        dn_v;
        bit          c_er;
        logic        er_v;
        bit          c_crc;
        logic [15:0] crc_v;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;

    task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic check_item(input exp_t e);
        logic        a_do, a_dn, a_er;
        logic [15:0] a_crc;
        a_do  = e.sel ? if16.data_out : if5.data_out;
        a_dn  = e.sel ? if16.crc_done : if5.crc_done;
        a_er  = e.sel ? if16.error    : if5.error;
        a_crc = e.sel ? if16.crc_value : {11'd0, if5.crc_value};
        if (e.c_do)  cmp({e.name, "/data_out"},  {15'd0, a_do}, {15'd0, e.do_v});
        if (e.c_dn)  cmp({e.name, "/crc_done"},  {15'd0, a_dn}, {15'd0, e.dn_v});
        if (e.c_er)  cmp({e.name, "/error"},     {15'd0, a_er}, {15'd0, e.er_v});
        if (e.c_crc) cmp({e.name, "/crc_value"}, a_crc, e.crc_v);
    endtask

    // Monitor: after each edge, pop and compare every expectation due by now.
    always @(posedge clk_c) begin
        cyc = cyc + 1;
        #1;
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            mon_e = sb_q.pop_front();
            check_item(mon_e);
        end
    end

    task automatic drive(input bit sel, input logic rst, input logic halt, input logic cwe,
                         input logic chk, input logic din);
        @(negedge clk_c);
        reset = rst;
        if5.halt_tx  = (sel == 1'b0) ? halt : 1'b0;
        if5.cwe_z    = (sel == 1'b0) ? cwe  : 1'b1;
        if5.chck_enbl= (sel == 1'b0) ? chk  : 1'b0;
        if5.data_in  = (sel == 1'b0) ? din  : 1'b0;
        if16.halt_tx  = (sel == 1'b1) ? halt : 1'b0;
        if16.cwe_z    = (sel == 1'b1) ? cwe  : 1'b1;
        if16.chck_enbl= (sel == 1'b1) ? chk  : 1'b0;
        if16.data_in  = (sel == 1'b1) ? din  : 1'b0;
    endtask

    task automatic expect_o(input bit sel, input string nm, input int dv, input int dn,
                            input int er, input int crc);
        exp_t e;
        e.sel = sel; e.cyc = cyc + 1; e.name = nm;
        e.c_do = (dv >= 0);  e.do_v = dv[0];
        e.c_dn = (dn >= 0);  e.dn_v = dn[0];
        e.c_er = (er >= 0);  e.er_v = er[0];
        e.c_crc = (crc >= 0); e.crc_v = crc[15:0];
        if (e.c_do || e.c_dn || e.c_er || e.c_crc) sb_q.push_back(e);
    endtask

    task automatic step(input bit sel, input logic rst, input logic halt, input logic cwe,
                        input logic chk, input logic din, input string nm,
                        input int dv, input int dn, input int er, input int crc);
        drive(sel, rst, halt, cwe, chk, din);
        expect_o(sel, nm, dv, dn, er, crc);
    endtask

    int tx5[5]      = '{0, 1, 0, 0, 0};
    int ap_good[5]  = '{1, 0, 0, 1, 1};
    int ap_bad[5]   = '{0, 1, 0, 0, 1};
    int rx5[16]     = '{0,0,0,0,0,0,0,0,0,0,0, 0,1,0,0,0};

    task automatic prep_append5();
        for (int i = 0; i < 11; i++)
            step(0, 0, 0, 0, 0, 0, "pre_data", 0, 0, X, (i == 10) ? 5'h17 : X);
        step(0, 0, 0, 1, 0, 0, "pre_tr", 0, 0, X, 5'h17);
        step(0, 0, 0, 1, 0, 0, "pre_ap0", 0, 0, X, 5'h0E);
        step(0, 0, 0, 1, 0, 0, "pre_ap1", 1, 0, X, 5'h1C);
    endtask

    initial begin
        if5.halt_tx = 1'b0; if5.cwe_z = 1'b1; if5.chck_enbl = 1'b0; if5.data_in = 1'b0;
        if16.halt_tx = 1'b0; if16.cwe_z = 1'b1; if16.chck_enbl = 1'b0; if16.data_in = 1'b0;

        step(0, 1, 0, 1, 0, 0, "rst5", 0, 0, 0, 5'h1F);
        expect_o(1, "rst16", 0, 0, 0, 16'hFFFF);
        step(0, 1, 0, 1, 0, 0, "rst5b", X, X, X, X);

        // CRC16: reach APPEND, abort to get DATA with a clean INIT, then append nothing but INIT.
        step(1, 0, 0, 0, 0, 0, "c16_prime", 0, 0, X, X);
        step(1, 0, 0, 1, 0, 0, "c16_tr", 0, 0, X, X);
        step(1, 0, 0, 1, 0, 0, "c16_ap1", X, 0, X, X);
        step(1, 0, 0, 0, 0, 0, "c16_abort", X, 0, X, 16'hFFFF);
        step(1, 0, 0, 1, 0, 0, "c16_tr2", 0, 0, X, 16'hFFFF);
        for (int i = 0; i < 16; i++)
            step(1, 0, 0, 1, 0, 0, "c16_tx", 0, (i == 15) ? 1 : 0, X, (i == 15) ? 16'hFFFF : X);
        step(1, 0, 0, 1, 0, 0, "c16_idle", 0, 0, X, 16'hFFFF);
        for (int i = 0; i < 16; i++)
            step(1, 0, 0, 0, 0, 0, "c16_rx", 0, 0, X, X);
        step(1, 0, 0, 1, 1, 0, "c16_chk", 0, 0, 0, 16'h800D);
        for (int i = 0; i < 16; i++)
            step(1, 0, 0, 1, 0, 0, "c16_ap", X, (i == 15) ? 1 : 0, X, (i == 15) ? 16'hFFFF : X);

        // CRC5 transmit of 11 zero bits.
        for (int i = 0; i < 11; i++)
            step(0, 0, 0, 0, 0, 0, "c5_tx_data", 0, 0, 0,
                 (i == 0) ? 5'h1B : ((i == 10) ? 5'h17 : X));
        step(0, 0, 0, 1, 0, 0, "c5_tx_tr", 0, 0, X, 5'h17);
        for (int i = 0; i < 5; i++)
            step(0, 0, 0, 1, 0, 0, "c5_tx_crc", tx5[i], (i == 4) ? 1 : 0, X, (i == 4) ? 5'h1F : X);
        step(0, 0, 0, 1, 0, 0, "c5_idle", 0, 0, X, 5'h1F);

        // CRC5 receive, good packet.
        for (int i = 0; i < 16; i++)
            step(0, 0, 0, 0, 0, rx5[i][0], "c5_rx", rx5[i], 0, X, X);
        step(0, 0, 0, 1, 1, 0, "c5_rx_chk", 0, 0, 0, 5'h0C);
        for (int i = 0; i < 5; i++)
            step(0, 0, 0, 1, 0, 0, "c5_rx_ap", ap_good[i], (i == 4) ? 1 : 0, 0, (i == 4) ? 5'h1F : X);

        // CRC5 receive with the first CRC bit flipped.
        rx5[11] = 1;
        for (int i = 0; i < 16; i++)
            step(0, 0, 0, 0, 0, rx5[i][0], "c5_bad_rx", rx5[i], 0, X, X);
        step(0, 0, 0, 1, 1, 0, "c5_bad_chk", 0, 0, 1, 5'h16);
        for (int i = 0; i < 5; i++)
            step(0, 0, 0, 1, 0, 0, "c5_bad_ap", ap_bad[i], (i == 4) ? 1 : 0, 1, (i == 4) ? 5'h1F : X);

        // Stall mid-append; the checker strobe is ignored while halted.
        prep_append5();
        for (int i = 0; i < 3; i++)
            step(0, 0, 1, 1, (i == 1) ? 1'b1 : 1'b0, 0, "c5_halt", 1, 0, 1, 5'h1C);
        step(0, 0, 0, 1, 0, 0, "c5_resume", 0, 0, 1, 5'h18);
        step(0, 0, 0, 1, 0, 0, "c5_resume", 0, 0, 1, 5'h10);
        step(0, 0, 0, 1, 0, 0, "c5_resume", 0, 1, 1, 5'h1F);
        step(0, 0, 0, 1, 0, 0, "c5_after", 0, 0, 1, 5'h1F);

        // Abort after two CRC bits; next data bit accumulates from INIT.
        prep_append5();
        step(0, 0, 0, 0, 0, 1, "c5_abort", X, 0, 1, 5'h1F);
        step(0, 0, 0, 0, 0, 0, "c5_ab_d0", 0, 0, 1, 5'h1B);
        step(0, 0, 0, 0, 0, 1, "c5_ab_d1", 1, 0, 1, 5'h16);

        // Reset during DATA with error set; afterwards the FSM must sit in IDLE.
        step(0, 1, 0, 0, 0, 1, "c5_rst", 0, 0, 0, 5'h1F);
        for (int i = 0; i < 7; i++)
            step(0, 0, 0, 1, 0, 0, "c5_post_rst", 0, 0, 0, 5'h1F);
        step(0, 0, 0, 0, 0, 1, "c5_post_d1", 1, 0, 0, 5'h1E);

        repeat (3) @(negedge clk_c);
        if (sb_q.size() != 0) begin
            n_total++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected end of stimulus");
        $fatal(1, "watchdog");
    end

endmodule
